tow_referee: RTL and testbench
==============================

TOW_REFEREE -- requirements
Module: tow_referee

Interface
REQ-001 The block SHALL have parameter FIELD, default 4: steps from centre to either win line; legal range 2..7.
REQ-002 The block SHALL have parameter ROUNDS_TO_WIN, default 3: round wins that end a match; legal range 1..15.
REQ-003 The block SHALL have parameter GO_DELAY, default 8: length of the COUNTDOWN state in cycles; must be >= 1.
REQ-004 The block SHALL have parameter HOLD, default 4: length of the ROUND_END state in cycles; must be >= 1.
REQ-005 The block SHALL have the following ports; clock first, then reset:
  clk  in  1  system clock; all state changes on the rising edge.
  reset  in  1  asynchronous reset, active-low.
  start  in  1  single-cycle pulse: begin or restart a match.
  press1  in  1  single-cycle pulse: player 1 pull, already debounced and edge-detected.
  press2  in  1  single-cycle pulse: player 2 (cyber) pull.
  pos  out  POS_W  rope position, 0..2*FIELD; centre is FIELD; POS_W = clog2(2*FIELD+1).
  score1, score2  out  4 each  round wins in the current match.
  round_win1, round_win2  out  1 each  one-cycle pulse when a round is won.
  go  out  1  high while in PLAY.
  match_over  out  1  high while in MATCH_END.
  state  out  3  current FSM state encoding, for debug.

Function
REQ-006 The FSM SHALL have exactly these states: IDLE, COUNTDOWN, PLAY, ROUND_END, MATCH_END.
REQ-007 In IDLE or MATCH_END, start SHALL clear both scores, set pos=FIELD, and enter COUNTDOWN; start SHALL be ignored in every other state.
REQ-008 COUNTDOWN SHALL last exactly GO_DELAY cycles and then enter PLAY; go SHALL assert on the first PLAY cycle.
REQ-009 In PLAY, a lone press1 SHALL increment pos and a lone press2 SHALL decrement pos, with the new value visible one cycle after the press.
REQ-010 When press1 and press2 arrive in the same cycle, pos SHALL remain unchanged (presses cancel).
REQ-011 On the edge at which pos reaches 2*FIELD (or 0), the block SHALL enter ROUND_END, increment score1 (or score2), and assert round_win1 (or round_win2) for exactly the first ROUND_END cycle.
REQ-012 ROUND_END SHALL last exactly HOLD cycles, with pos frozen at the win line.
REQ-013 At the end of ROUND_END, if the winner's score equals ROUNDS_TO_WIN the block SHALL enter MATCH_END; otherwise it SHALL set pos=FIELD and enter COUNTDOWN.
REQ-014 Presses SHALL be ignored in IDLE, ROUND_END and MATCH_END, and in COUNTDOWN unless TOW_FALSE_START_EN is defined.
REQ-015 Scores SHALL never exceed ROUNDS_TO_WIN, and pos SHALL never leave 0..2*FIELD.
REQ-016 All outputs SHALL be registered or decoded only from state, with no combinational path from any input to any output.

Reset
REQ-017 While reset is low, the block SHALL asynchronously force state=IDLE, pos=FIELD, score1=score2=0, round_win1=round_win2=0, go=0, match_over=0 and clear the timer.
REQ-018 Reset asserted mid-round SHALL discard the round in progress; after reset deasserts, the block SHALL remain in IDLE until start.

Configuration
REQ-019 With TOW_FALSE_START_EN defined, a lone press in COUNTDOWN SHALL move pos one step toward the opponent (press1 decrements, press2 increments), saturating at 1 and 2*FIELD-1 so that a false start never wins a round; simultaneous presses SHALL cancel.
REQ-020 With TOW_FALSE_START_EN undefined, presses in COUNTDOWN SHALL have no effect, and the false-start logic SHALL not be synthesised.

Structure
REQ-021 Shared package tow_pkg SHALL hold the state enum tow_state_t (3-bit) and the default constants for FIELD, ROUNDS_TO_WIN, GO_DELAY and HOLD.
REQ-022 A sub-module tow_timer (loadable down-counter with a done flag) SHALL time both COUNTDOWN and ROUND_END.

Verification (defaults)
REQ-023 Bench SHALL cover: reset low, then start -> go rises exactly 8 cycles after COUNTDOWN entry, with pos=4.
REQ-024 Bench SHALL cover: in PLAY, 4 lone press1 pulses -> pos goes 5,6,7,8; round_win1 is a 1-cycle pulse; score1=1; after 4 cycles, COUNTDOWN with pos=4.
REQ-025 Bench SHALL cover: press1 and press2 in the same cycle for 10 cycles -> pos stays 4 and no win.
REQ-026 Bench SHALL cover: player 2 wins 3 rounds -> score2=3, match_over=1; a further start -> scores 0, COUNTDOWN.
REQ-027 Bench SHALL cover: with TOW_FALSE_START_EN defined, 5 press1 pulses during COUNTDOWN -> pos 3,2,1,1,1 and no round end; with it undefined -> pos stays 4.
REQ-028 Bench SHALL cover: reset pulsed low with pos=7 in PLAY -> immediate IDLE, pos=4, scores 0; start and press pulses during reset are ignored.

Source files
------------

// File: rtl/tow_pkg.sv
// tow_pkg: shared state encoding and default parameters for the tug-of-war referee.
package tow_pkg;
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_ROUND_END = 3'd3,
    S_MATCH_END = 3'd4
  } tow_state_t;
  localparam int FIELD_DEF         = 4;
  localparam int ROUNDS_TO_WIN_DEF = 3;
  localparam int GO_DELAY_DEF      = 8;
  localparam int HOLD_DEF          = 4;
endpackage

// File: rtl/tow_timer.sv
// tow_timer: loadable down-counter; done is high while the count is zero.
//   clk, reset (async, active-low), load/load_val reload the count, done flags zero.
module tow_timer
  import tow_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load ? load_val : (count_q != '0 ? count_q - 1'b1 : count_q);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count_q <= '0;
    else count_q <= count_d;
  assign done = count_q == '0;
endmodule

// File: rtl/tow_referee.sv
// tow_referee: two-player tug-of-war referee FSM (rope position, round and match scoring).
//   Inputs : clk, reset (async, active-low), start, press1, press2 (single-cycle pulses).
//   Outputs: pos (rope position, centre = FIELD), score1/score2, round_win1/round_win2 pulses,
//            go (PLAY), match_over (MATCH_END), state (debug encoding).
//   Build option: TOW_FALSE_START_EN makes a lone press during COUNTDOWN push the rope
//   one step toward the opponent, never onto a win line.
module tow_referee
  import tow_pkg::*;
#(
  parameter int FIELD         = FIELD_DEF,
  parameter int ROUNDS_TO_WIN = ROUNDS_TO_WIN_DEF,
  parameter int GO_DELAY      = GO_DELAY_DEF,
  parameter int HOLD          = HOLD_DEF,
  localparam int POS_W        = $clog2(2 * FIELD + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             press1,
  input  logic             press2,
  output logic [POS_W-1:0] pos,
  output logic [3:0]       score1,
  output logic [3:0]       score2,
  output logic             round_win1,
  output logic             round_win2,
  output logic             go,
  output logic             match_over,
  output logic [2:0]       state
);
  localparam int MAXD = GO_DELAY > HOLD ? GO_DELAY : HOLD;
  localparam int TW   = $clog2(MAXD + 1);
  localparam logic [POS_W-1:0] CENTRE   = POS_W'(FIELD);
  localparam logic [POS_W-1:0] TOP      = POS_W'(2 * FIELD);
  localparam logic [POS_W-1:0] NEAR_TOP = POS_W'(2 * FIELD - 1);
  localparam logic [POS_W-1:0] NEAR_BOT = POS_W'(1);
  localparam logic [3:0]       WIN      = 4'(ROUNDS_TO_WIN);

  tow_state_t       state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [3:0]       score1_q, score1_d, score2_q, score2_d;
  logic             rw1_q, rw1_d, rw2_q, rw2_d;
  logic             t_load, t_done;
  logic [TW-1:0]    t_val;
  logic             lone1, lone2;

  assign lone1 = press1 & ~press2;
  assign lone2 = press2 & ~press1;

  // Timer is loaded with length-1 on entry so that done lands on the state's last cycle.
  tow_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (t_load),
    .load_val(t_val),
    .done    (t_done)
  );

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    score1_d = score1_q;
    score2_d = score2_q;
    rw1_d    = 1'b0;
    rw2_d    = 1'b0;
    t_load   = 1'b0;
    t_val    = TW'(GO_DELAY - 1);
    case (state_q)
      S_IDLE, S_MATCH_END:
        if (start) begin
          state_d  = S_COUNTDOWN;
          pos_d    = CENTRE;
          score1_d = '0;
          score2_d = '0;
          t_load   = 1'b1;
        end
      S_COUNTDOWN: begin
        if (t_done) state_d = S_PLAY;
`ifdef TOW_FALSE_START_EN
        // A false start penalises the presser but stops one short of the win line.
        if (lone1 && pos_q > NEAR_BOT) pos_d = pos_q - 1'b1;
        if (lone2 && pos_q < NEAR_TOP) pos_d = pos_q + 1'b1;
`endif
      end
      S_PLAY:
        if (lone1) begin
          pos_d = pos_q + 1'b1;
          if (pos_q == NEAR_TOP) begin
            state_d  = S_ROUND_END;
            score1_d = score1_q + 1'b1;
            rw1_d    = 1'b1;
            t_load   = 1'b1;
            t_val    = TW'(HOLD - 1);
          end
        end else if (lone2) begin
          pos_d = pos_q - 1'b1;
          if (pos_q == NEAR_BOT) begin
            state_d  = S_ROUND_END;
            score2_d = score2_q + 1'b1;
            rw2_d    = 1'b1;
            t_load   = 1'b1;
            t_val    = TW'(HOLD - 1);
          end
        end
      S_ROUND_END:
        // The frozen rope position identifies the round winner.
        if (t_done) begin
          if ((pos_q == TOP ? score1_q : score2_q) == WIN) state_d = S_MATCH_END;
          else begin
            state_d = S_COUNTDOWN;
            pos_d   = CENTRE;
            t_load  = 1'b1;
          end
        end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= S_IDLE;
      pos_q    <= CENTRE;
      score1_q <= '0;
      score2_q <= '0;
      rw1_q    <= 1'b0;
      rw2_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      score1_q <= score1_d;
      score2_q <= score2_d;
      rw1_q    <= rw1_d;
      rw2_q    <= rw2_d;
    end

  assign pos        = pos_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign round_win1 = rw1_q;
  assign round_win2 = rw2_q;
  assign go         = state_q == S_PLAY;
  assign match_over = state_q == S_MATCH_END;
  assign state      = state_q;
endmodule

// File: tb/tb_tow_referee.sv
// tb_tow_referee: directed self-checking bench for tow_referee at default parameters.
module tb_tow_referee;
`ifdef TOW_FALSE_START_EN
  localparam bit FS = 1'b1;
`else
  localparam bit FS = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       press1 = 1'b0;
  logic       press2 = 1'b0;
  logic [3:0] pos;
  logic [3:0] score1, score2;
  logic       round_win1, round_win2, go, match_over;
  logic [2:0] state;
  int checks = 0;
  int errors = 0;

  tow_referee dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .press1    (press1),
    .press2    (press2),
    .pos       (pos),
    .score1    (score1),
    .score2    (score2),
    .round_win1(round_win1),
    .round_win2(round_win2),
    .go        (go),
    .match_over(match_over),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs for one rising edge; outputs are observed at the following falling edge.
  task automatic cyc(input bit s, input bit p1, input bit p2);
    start = s;
    press1 = p1;
    press2 = p2;
    @(negedge clk);
    start = 1'b0;
    press1 = 1'b0;
    press2 = 1'b0;
  endtask

  task automatic wait_play();
    int n = 0;
    while (!go && n < 20) begin
      cyc(0, 0, 0);
      n++;
    end
    chk("wait_play", int'(go), 1);
  endtask

  task automatic p2_round(input int sc);
    wait_play();
    for (int i = 0; i < 4; i++) cyc(0, 0, 1);
    chk("p2_win_pos", pos, 0);
    chk("p2_win_pulse", round_win2, 1);
    chk("p2_score", score2, sc);
    cyc(0, 0, 0);
    chk("p2_pulse_end", round_win2, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("p2_after_hold", state, sc == 3 ? 4 : 1);
  endtask

  initial begin
    int e;
    repeat (2) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_pos", pos, 4);
    chk("rst_scores", score1 + score2, 0);
    chk("rst_flags", {go, match_over, round_win1, round_win2}, 0);
    reset = 1'b1;
    repeat (3) cyc(0, 1, 0);
    chk("idle_hold", state, 0);
    chk("idle_pos", pos, 4);

    cyc(1, 0, 0);
    chk("cd_entry", state, 1);
    chk("cd_pos", pos, 4);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0);
    chk("cd_go_low_7", go, 0);
    cyc(0, 0, 0);
    chk("cd_go_high_8", go, 1);
    chk("play_pos", pos, 4);

    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0);
      chk("p1_pos", pos, 5 + i);
    end
    chk("p1_state_re", state, 3);
    chk("p1_pulse", round_win1, 1);
    chk("p1_score", score1, 1);
    cyc(0, 0, 0);
    chk("p1_pulse_end", round_win1, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 1);
    chk("re_frozen_pos", pos, 8);
    chk("re_state", state, 3);
    cyc(0, 0, 0);
    chk("re_to_cd", state, 1);
    chk("re_centre", pos, 4);
    chk("re_score_kept", score1, 1);

    cyc(0, 1, 1);
    chk("cd_both_pos", pos, 4);
    wait_play();
    for (int i = 0; i < 10; i++) cyc(0, 1, 1);
    chk("both_pos", pos, 4);
    chk("both_state", state, 2);
    chk("both_score", score1 + score2, 1);

    p2_round(1);
    p2_round(2);
    p2_round(3);
    chk("match_over", match_over, 1);
    chk("match_pos", pos, 0);
    cyc(0, 1, 0);
    chk("match_ignore_press", pos, 0);
    chk("match_score1", score1, 1);

    cyc(1, 0, 0);
    chk("restart_state", state, 1);
    chk("restart_scores", score1 + score2, 0);
    chk("restart_over", match_over, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 0);
      e = FS ? ((3 - i) < 1 ? 1 : 3 - i) : 4;
      chk("fs_pos", pos, e);
      chk("fs_state", state, 1);
    end
    wait_play();
    e = FS ? 1 : 4;
    chk("fs_play_pos", pos, e);
    for (int i = 0; i < 7 - e; i++) cyc(0, 1, 0);
    chk("pre_rst_pos", pos, 7);
    chk("pre_rst_state", state, 2);

    #2;
    reset = 1'b0;
    start = 1'b1;
    press1 = 1'b1;
    #1;
    chk("async_state", state, 0);
    chk("async_pos", pos, 4);
    chk("async_go", go, 0);
    @(negedge clk);
    cyc(1, 1, 0);
    chk("rst_ignore_state", state, 0);
    chk("rst_ignore_pos", pos, 4);
    reset = 1'b1;
    repeat (3) cyc(0, 1, 0);
    chk("post_rst_idle", state, 0);
    chk("post_rst_scores", score1 + score2, 0);
    cyc(1, 0, 0);
    chk("post_rst_start", state, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
